eth_tx_frame_fifo: RTL and testbench
====================================

ETH_TX_FRAME_FIFO -- requirements
Module: eth_tx_frame_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 512, FIFO depth in 64-bit words (power of two).
REQ-002 SHALL have parameter MAX_FRAME_WORDS, default 190, largest accepted frame in words (1518 B rounded up); DEPTH > MAX_FRAME_WORDS.
REQ-003 SHALL have port clk156  input  1  the single clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports s_axis_tvalid/tready/tlast  in/out/in  1  upstream frame stream from the TLP packetizer, network byte order (byte 0 in tdata[63:56]).
REQ-006 SHALL have ports s_axis_tdata  input  64, s_axis_tkeep  input  8  (tkeep[7] = byte 0).
REQ-007 SHALL have ports m_axis_tvalid/tready/tlast  out/in/out  1  to the 10G MAC TX stream.
REQ-008 SHALL have ports m_axis_tdata  output  64, m_axis_tkeep  output  8, m_axis_tuser  output  1  MAC lane order (byte 0 in tdata[7:0]).
REQ-009 SHALL have ports frame_cnt  output  32, drop_cnt  output  32  status counters.

Function
REQ-010 SHALL operate store-and-forward: no word of a frame is presented on m_axis until its tlast word is written.
REQ-011 SHALL byte-reverse on the output path: m_tdata byte lane i = stored byte lane 7-i; m_tkeep[i] = stored tkeep[7-i].
REQ-012 SHALL assert s_axis_tready when at least one free word exists or in DROP state; accept a word on tvalid && tready.
REQ-013 SHALL track wr_ptr (speculative) and wr_commit; on accepted tlast word, wr_commit <= wr_ptr+1 and committed-frame count increments.
REQ-014 SHALL, write FSM states ACCEPT/DROP: ACCEPT->DROP when an accepted non-last word makes frame length reach MAX_FRAME_WORDS, or a non-last word has tkeep != 8'hFF; on entry wr_ptr rewinds to wr_commit and drop_cnt increments.
REQ-015 SHALL in DROP hold tready=1, discard words, return to ACCEPT after the accepted tlast word.
REQ-016 SHALL treat a tlast word with tkeep == 0 as a drop (frame discarded, drop_cnt increments, stay ACCEPT).
REQ-017 SHALL, read FSM states IDLE/SEND: IDLE->SEND when committed-frame count > 0; SEND->IDLE after m_axis tlast handshake, decrementing count.
REQ-018 SHALL keep m_axis_tvalid continuously high from first to last word of a frame whenever tready is high (no intra-frame bubbles); output is registered.
REQ-019 SHALL present the first word of a frame on m_axis no later than 3 cycles after its tlast is accepted with empty FIFO and m_tready=1.
REQ-020 SHALL allow back-to-back frames: next frame's first word valid the cycle after previous tlast handshake when committed.
REQ-021 SHALL, on simultaneous commit and read-complete, leave committed-frame count unchanged.
REQ-022 SHALL drive m_axis_tuser = 0 always (underrun never signalled).
REQ-023 SHALL wrap pointers modulo DEPTH using one extra MSB for full/empty distinction.
REQ-024 SHALL increment frame_cnt on each m_axis tlast handshake; both counters saturate at 32'hFFFFFFFF.

Reset
REQ-025 SHALL on sys_rst_n low clear all pointers, counts, counters, states (ACCEPT, IDLE); m_axis_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, s_axis_tready=0 during reset.
REQ-026 SHALL discard any partial or committed frame on reset mid-operation; s_axis_tready rises the first cycle after deassertion.

Configuration
REQ-027 SHALL, with macro ETH_TX_STATS_EN defined, implement frame_cnt and drop_cnt per REQ-014/016/024; without it both outputs tie to 0 and no counter flops exist.

Structure
REQ-028 SHALL place in shared package eth_tx_pkg: stored-word struct typedef (64 data, 8 keep, 1 last), write/read FSM state enums, byte-reverse function.
REQ-029 SHALL instantiate one sub-module eth_tx_ram: simple dual-port, one-cycle read latency, DEPTH x 73 bits.

Verification
REQ-030 SHALL cover: 8-word frame, data 64'h0011223344556677 word 0, last tkeep 8'hF0 -> m_tdata 64'h7766554433221100 word 0, last m_tkeep 8'h0F, tuser 0, frame_cnt=1.
REQ-031 SHALL cover: 191-word frame without tlast at word 190 -> frame absent on m_axis, drop_cnt=1, following 4-word frame delivered intact.
REQ-032 SHALL cover: non-last word tkeep 8'h7F -> frame dropped, drop_cnt=1, tready stays 1 until tlast.
REQ-033 SHALL cover: m_tready toggling 1/0 over three queued 64-word frames -> all 192 words delivered in order, tvalid never drops mid-frame while tready=1.
REQ-034 SHALL cover: sys_rst_n pulsed low at word 5 of a 10-word input frame -> m_tvalid=0, counters 0, next 2-word frame delivered correctly.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared types for the 10G TX frame FIFO: stored word layout, FSM states,
// and the network-to-MAC byte-lane reversal.
package eth_tx_pkg;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } tx_word_t;

    typedef enum logic {ACCEPT, DROP} wr_state_t;
    typedef enum logic {IDLE, SEND}   rd_state_t;

    // Network order keeps byte 0 in the top lane; the MAC wants it in lane 0.
    function automatic tx_word_t byte_reverse(input tx_word_t w);
        tx_word_t r;
        r.last = w.last;
        for (int i = 0; i < 8; i++) begin
            r.data[8*i +: 8] = w.data[8*(7-i) +: 8];
            r.keep[i]        = w.keep[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_tx_ram.sv
// Simple dual-port frame storage, DEPTH x 73 bits, one-cycle registered read.
module eth_tx_ram
    import eth_tx_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  tx_word_t      wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output tx_word_t      rdata
);

    tx_word_t mem [DEPTH];

    // rdata holds its value while re is low, so it doubles as a pipeline stage.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/eth_tx_frame_fifo.sv
// Store-and-forward 64-bit TX frame FIFO between the TLP packetizer and the 10G MAC.
// Define ETH_TX_STATS_EN to build the frame_cnt/drop_cnt status counters.
module eth_tx_frame_fifo
    import eth_tx_pkg::*;
#(
    parameter int DEPTH           = 512,
    parameter int MAX_FRAME_WORDS = 190
) (
    input  logic        clk156,
    input  logic        sys_rst_n,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tuser,
    output logic [31:0] frame_cnt,
    output logic [31:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(MAX_FRAME_WORDS + 1);
    typedef logic [AW:0] ptr_t;

    wr_state_t     wr_state, wr_next;
    rd_state_t     rd_state, rd_next;
    ptr_t          wr_ptr, wr_commit, rd_ptr, frames;
    logic [LW-1:0] frm_len;
    logic          rdy_en, full, s_hs, bad_keep, len_hit;
    logic          wr_en, commit, drop_evt;
    logic          rd_en, load_p2, frame_done, vld_p1;
    tx_word_t      wr_word, rd_word_p1, out_word;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign s_hs     = s_axis_tvalid && s_axis_tready;
    assign bad_keep = (s_axis_tkeep != 8'hFF);
    assign len_hit  = (frm_len == LW'(MAX_FRAME_WORDS - 1));
    assign wr_word  = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) wr_state <= ACCEPT;
        else            wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            ACCEPT:  if (s_hs && !s_axis_tlast && (bad_keep || len_hit)) wr_next = DROP;
            DROP:    if (s_hs && s_axis_tlast) wr_next = ACCEPT;
            default: wr_next = ACCEPT;
        endcase
    end

    always_comb begin
        s_axis_tready = 1'b0;
        wr_en         = 1'b0;
        commit        = 1'b0;
        drop_evt      = 1'b0;
        case (wr_state)
            ACCEPT: begin
                s_axis_tready = rdy_en && !full;
                wr_en         = s_hs;
                commit        = s_hs && s_axis_tlast && (s_axis_tkeep != 8'h00);
                drop_evt      = s_hs && (s_axis_tlast ? (s_axis_tkeep == 8'h00)
                                                      : (bad_keep || len_hit));
            end
            DROP:    s_axis_tready = rdy_en;
            default: ;
        endcase
    end

    // wr_ptr runs ahead of wr_commit until tlast; a drop rewinds it.
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rdy_en    <= 1'b0;
            wr_ptr    <= '0;
            wr_commit <= '0;
            frm_len   <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (drop_evt) begin
                wr_ptr  <= wr_commit;
                frm_len <= '0;
            end else if (commit) begin
                wr_ptr    <= wr_ptr + ptr_t'(1);
                wr_commit <= wr_ptr + ptr_t'(1);
                frm_len   <= '0;
            end else if (wr_en) begin
                wr_ptr  <= wr_ptr + ptr_t'(1);
                frm_len <= frm_len + LW'(1);
            end
        end
    end

    eth_tx_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk156),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_word),
        .re    (rd_en),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_word_p1)
    );

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) rd_state <= IDLE;
        else            rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            IDLE:    if (frames != '0) rd_next = SEND;
            SEND:    if (frame_done) rd_next = IDLE;
            default: rd_next = IDLE;
        endcase
    end

    // Reads run over every committed word, so a following frame streams without a gap.
    always_comb begin
        load_p2    = vld_p1 && (!m_axis_tvalid || m_axis_tready);
        rd_en      = (rd_ptr != wr_commit) && (!vld_p1 || load_p2);
        frame_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    end

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_ptr <= '0;
            frames <= '0;
        end else begin
            if (rd_en) rd_ptr <= rd_ptr + ptr_t'(1);
            case ({commit, frame_done})
                2'b10:   frames <= frames + ptr_t'(1);
                2'b01:   frames <= frames - ptr_t'(1);
                default: ;
            endcase
        end
    end

    assign out_word = byte_reverse(rd_word_p1);

    // p1: RAM read register -> p2: registered m_axis outputs
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_p1        <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
        end else begin
            if (rd_en)        vld_p1 <= 1'b1;
            else if (load_p2) vld_p1 <= 1'b0;
            if (load_p2) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= out_word.last;
                m_axis_tdata  <= out_word.data;
                m_axis_tkeep  <= out_word.keep;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tuser = 1'b0;

`ifdef ETH_TX_STATS_EN
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (frame_done && (frame_cnt != '1)) frame_cnt <= frame_cnt + 32'd1;
            if (drop_evt && (drop_cnt != '1))    drop_cnt  <= drop_cnt + 32'd1;
        end
    end
`else
    assign frame_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// Bench for eth_tx_frame_fifo: randomized frames checked against a frame-level
// reference queue built from the accept/drop rules and a byte-lane reversal.
module tb_eth_tx_frame_fifo;

    localparam int MAXW = 190;
`ifdef ETH_TX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk156        = 1'b0;
    logic        sys_rst_n     = 1'b1;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast  = 1'b0;
    logic [63:0] s_axis_tdata  = '0;
    logic [7:0]  s_axis_tkeep  = '0;
    logic        s_axis_tready;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic        m_axis_tready = 1'b0;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic [31:0] frame_cnt, drop_cnt;

    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 0;
    bit          in_frame = 1'b0;
    logic [72:0] got[$];
    logic [72:0] exp_q[$];
    int          exp_frames = 0;
    int          exp_drops = 0;
    bit          force_w0 = 1'b0;
    logic [63:0] w0_val = '0;

    always #5 clk156 = ~clk156;

    eth_tx_frame_fifo dut (
        .clk156        (clk156),
        .sys_rst_n     (sys_rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .frame_cnt     (frame_cnt),
        .drop_cnt      (drop_cnt)
    );

    task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, " frame_cnt"}, 73'(frame_cnt), STATS ? 73'(exp_frames) : 73'd0);
        chk({tag, " drop_cnt"},  73'(drop_cnt),  STATS ? 73'(exp_drops)  : 73'd0);
    endtask

    // Sink: sets m_axis_tready for the coming edge, then records the handshake it implies.
    always @(negedge clk156) begin
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            2:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
        endcase
        if (!sys_rst_n) begin
            in_frame = 1'b0;
        end else begin
            if (in_frame && m_axis_tready) chk("tvalid_mid_frame", 73'(m_axis_tvalid), 73'd1);
            if (m_axis_tvalid && m_axis_tready) begin
                got.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
                chk("tuser", 73'(m_axis_tuser), 73'd0);
                in_frame = !m_axis_tlast;
            end
        end
    end

    // Source: drives one frame; bad_idx marks a non-last word with tkeep 8'h7F,
    // abort_at stops the frame before that word is driven.
    task automatic send_frame(input int len, input int bad_idx, input logic [7:0] last_keep,
                              input int abort_at, input bit gaps);
        logic [72:0] frm[$];
        logic [63:0] d, rd;
        logic [7:0]  k, rk;
        bit          dropping;
        bit          ok;
        int          guard;
        dropping = 1'b0;
        for (int w = 0; w < len; w++) begin
            if (w == abort_at) begin
                @(negedge clk156);
                s_axis_tvalid = 1'b0;
                return;
            end
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                @(negedge clk156);
                s_axis_tvalid = 1'b0;
            end
            d = (w == 0 && force_w0) ? w0_val : {$urandom, $urandom};
            k = (w == len - 1) ? last_keep : ((w == bad_idx) ? 8'h7F : 8'hFF);
            @(negedge clk156);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = d;
            s_axis_tkeep  = k;
            s_axis_tlast  = (w == len - 1);
            if (dropping) chk("tready_in_drop", 73'(s_axis_tready), 73'd1);
            guard = 0;
            while (!s_axis_tready && guard < 5000) begin
                @(negedge clk156);
                guard++;
            end
            if (guard >= 5000) begin
                chk("s_tready_timeout", 73'(guard), 73'd0);
                s_axis_tvalid = 1'b0;
                return;
            end
            @(posedge clk156);
            rd = {<<8{d}};
            rk = {<<{k}};
            frm.push_back({rd, rk, (w == len - 1)});
            if (w < len - 1 && (w == bad_idx || w + 1 == MAXW)) dropping = 1'b1;
        end
        @(negedge clk156);
        s_axis_tvalid = 1'b0;
        ok = (len <= MAXW) && !(bad_idx >= 0 && bad_idx < len - 1) && (last_keep != 8'h00);
        if (ok) begin
            foreach (frm[i]) exp_q.push_back(frm[i]);
            exp_frames++;
        end else begin
            exp_drops++;
        end
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (got.size() < exp_q.size() && guard < 4000) begin
            @(negedge clk156);
            guard++;
        end
        if (guard >= 4000) chk({tag, " drain_timeout"}, 73'(guard), 73'd0);
        repeat (20) @(negedge clk156);
    endtask

    task automatic compare_clear(input string tag);
        chk({tag, " word_count"}, 73'(got.size()), 73'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s word %0d", tag, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [72:0] t;
        bit          lat_ok;
        int          len, bad;
        logic [7:0]  lk;

        #2 sys_rst_n = 1'b0;
        repeat (3) @(negedge clk156);
        chk("rst m_tvalid", 73'(m_axis_tvalid), 73'd0);
        chk("rst m_tlast",  73'(m_axis_tlast),  73'd0);
        chk("rst m_tdata",  73'(m_axis_tdata),  73'd0);
        chk("rst m_tkeep",  73'(m_axis_tkeep),  73'd0);
        chk("rst s_tready", 73'(s_axis_tready), 73'd0);
        chk_counters("rst");
        sys_rst_n = 1'b1;
        @(negedge clk156);
        chk("s_tready after reset", 73'(s_axis_tready), 73'd1);

        // 8-word frame with a known first word and a partial last word
        force_w0 = 1'b1;
        w0_val   = 64'h0011223344556677;
        send_frame(8, -1, 8'hF0, -1, 1'b0);
        force_w0 = 1'b0;
        lat_ok = m_axis_tvalid;
        for (int n = 2; n <= 4; n++) begin
            @(negedge clk156);
            lat_ok = lat_ok | m_axis_tvalid;
        end
        chk("first word latency", 73'(lat_ok), 73'd1);
        drain("f8");
        if (got.size() == 8) begin
            t = got[0];
            chk("f8 word0 data", 73'(t[72:9]), 73'(64'h7766554433221100));
            t = got[7];
            chk("f8 last keep", 73'(t[8:1]), 73'(8'h0F));
            chk("f8 last flag", 73'(t[0]), 73'd1);
        end
        compare_clear("f8");
        chk_counters("f8");

        // oversize frame is dropped, following short frame and a max-size frame survive
        send_frame(191, -1, 8'hFF, -1, 1'b0);
        send_frame(4, -1, 8'hC0, -1, 1'b0);
        send_frame(190, -1, 8'hFF, -1, 1'b0);
        drain("oversize");
        compare_clear("oversize");
        chk_counters("oversize");

        // bad mid-frame keep, zero-keep last word, then a clean frame
        send_frame(6, 2, 8'hFF, -1, 1'b1);
        send_frame(3, -1, 8'h00, -1, 1'b0);
        send_frame(5, -1, 8'hFE, -1, 1'b1);
        drain("badkeep");
        compare_clear("badkeep");
        chk_counters("badkeep");

        // three queued 64-word frames drained with toggling tready
        rdy_mode = 3;
        for (int f = 0; f < 3; f++) send_frame(64, -1, 8'hFF, -1, 1'b0);
        rdy_mode = 1;
        drain("queued3");
        compare_clear("queued3");
        chk_counters("queued3");

        // random frames against random backpressure
        rdy_mode = 2;
        for (int f = 0; f < 12; f++) begin
            len = $urandom_range(1, 24);
            bad = (len > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(0, len - 2) : -1;
            lk  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) != 0 && lk == 8'h00) lk = 8'h80;
            send_frame(len, bad, lk, -1, 1'b1);
        end
        drain("random");
        compare_clear("random");
        chk_counters("random");

        // reset in the middle of an input frame
        rdy_mode = 0;
        send_frame(10, -1, 8'hFF, 5, 1'b0);
        sys_rst_n  = 1'b0;
        exp_frames = 0;
        exp_drops  = 0;
        repeat (2) @(negedge clk156);
        chk("midrst m_tvalid", 73'(m_axis_tvalid), 73'd0);
        chk("midrst s_tready", 73'(s_axis_tready), 73'd0);
        chk_counters("midrst");
        sys_rst_n = 1'b1;
        @(negedge clk156);
        chk("midrst tready rise", 73'(s_axis_tready), 73'd1);
        got.delete();
        exp_q.delete();
        send_frame(2, -1, 8'h80, -1, 1'b0);
        drain("postrst");
        compare_clear("postrst");
        chk_counters("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
